sobel_filter: RTL and testbench
===============================

# sobel_filter

Streaming 3x3 Sobel edge-magnitude stage that sits directly downstream of the camera row-delay stage in the Minilab 2 grayscale video path. It accepts one grayscale pixel per valid cycle in raster order and keeps two rows of history internally, gated by `in_valid`. It emits one edge-magnitude pixel per accepted input with a fixed 2-cycle latency. Its output feeds the VGA frame buffer writer.

## Interface
- `ROW_SIZE`, default 1280: pixels per row.
- `ROWS`, default 960: rows per frame.
- `PIXEL_SIZE`, default 12: bits per input and output pixel.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  `in_pixel` is accepted this cycle; no backpressure.
- `in_sof`  in  1  start of frame; qualified by `in_valid`.
- `in_pixel`  in  PIXEL_SIZE  grayscale pixel, unsigned.
- `out_valid`  out  1  `out_pixel` is valid.
- `out_sof`  out  1  start-of-frame marker, aligned with `out_valid`.
- `out_pixel`  out  PIXEL_SIZE  edge magnitude, unsigned.
- `threshold`  in  PIXEL_SIZE  binarize level; present only with `SOBEL_THRESH_EN`.

## Operation
- Column counter `col` runs 0..ROW_SIZE-1 and advances on each accepted pixel. On wrap to 0, row counter `row` increments, running 0..ROWS-1 and then wrapping to 0.
- Accepted pixel with `in_sof`=1: treated as position (0,0). Counters restart from it, even mid-frame.
- Two line memories of ROW_SIZE x PIXEL_SIZE, indexed by `col`.
  - Asynchronous read at `col`; write at `col` on accept.
  - Line 1 receives `in_pixel`. Line 2 receives the old line-1 value.
- 3x3 window registers shift left on accept only. New right column = {line2 read, line1 read, in_pixel} (top to bottom).
- Window p[r][c], r,c in 0..2, with c=2 the newest column:
  - Gx = (p02 + 2·p12 + p22) − (p00 + 2·p10 + p20)
  - Gy = (p20 + 2·p21 + p22) − (p00 + 2·p01 + p02)
  - Both are signed, PIXEL_SIZE+4 bits.
- mag = |Gx| + |Gy|, unsigned, PIXEL_SIZE+4 bits. Saturate to 2^PIXEL_SIZE−1.
- Border rule: if the accepted pixel had row<2 or col<2, output is 0. A valid is still emitted.
- Output k corresponds to input k, so the output pixel count always equals the input pixel count.

## Timing
- Cycle t: accept the pixel; counters update; line memory writes; window registers load at the end of t.
- Cycle t+1: Gx, Gy and saturated magnitude are computed and registered, together with the border flag and sof captured at t.
- Cycle t+2: `out_valid`=1 with `out_pixel` and `out_sof`. Latency is exactly 2 cycles.
- Gaps in `in_valid`:
  - The pipeline advances every cycle, carrying a valid bit with each stage.
  - Window and line memories hold during gaps.
  - Output gaps mirror input gaps.
- Reset values: `out_valid`=0, `out_sof`=0, `out_pixel`=0. Counters are 0 and pipeline valid bits are cleared.
- Line memories and window registers are not reset. The border mask hides their stale contents.
- Reset mid-frame takes effect in the next cycle. No output is produced for pixels accepted before reset.

## Configuration
- `SOBEL_THRESH_EN` defined:
  - Port `threshold` exists.
  - `out_pixel` = all-ones if saturated mag ≥ `threshold`, else 0.
  - Border pixels are always 0.
- Not defined: no `threshold` port; `out_pixel` carries the saturated magnitude.
- Latency is identical in both builds.

## Structure
- Package `sobel_pkg` holds:
  - Widths: `GRAD_W` = PIXEL_SIZE+4.
  - A typedef for the 3x3 window struct.
  - The saturation max constant.
- Sub-module `sobel_window` holds the two line memories, the 3x3 window registers and the col/row counters. Its outputs are the window and a border flag.
- The top level holds the gradient arithmetic, the saturation and the output registers.

## Test plan
Bench parameters: ROW_SIZE=8, ROWS=6, PIXEL_SIZE=12.
- Flat frame, all pixels 500 → every output is 0; 48 outputs; `out_sof` only on output 0.
- Vertical step: cols 0–3 = 0, cols 4–7 = 100, all rows → rows ≥2 give 400 at col 4 and col 5, 0 elsewhere; rows 0–1 give all 0.
- Saturation: cols 0–3 = 0, cols 4–7 = 4095 → 4095 at col 4 and col 5, rows ≥2.
- `in_valid` toggled 1-0-1-0 during the vertical-step frame → same values as the vertical-step case; each output appears exactly 2 cycles after its input.
- `in_sof` asserted at input index 20 of a running frame → output 20 has `out_sof`=1. The next 16 outputs are 0 (the two border rows of the restarted frame).
- `rst_n` low for 1 cycle mid-frame → `out_valid`=0 for the next 2 cycles. The first pixel after reset is treated as (0,0), and its output is 0.
- With `SOBEL_THRESH_EN` and `threshold`=300, vertical-step frame → 4095 at cols 4–5 for rows ≥2; 0 elsewhere.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared widths, saturation constant and 3x3 window type for the Sobel stage.
// PIX_W is the build pixel width; instantiate sobel_filter with PIXEL_SIZE == PIX_W.
package sobel_pkg;
  localparam int PIX_W  = 12;
  localparam int GRAD_W = PIX_W + 4;
  localparam logic [PIX_W-1:0] SAT_MAX = {PIX_W{1'b1}};

  // p[r][c]: r=0 top row (two lines back), c=2 newest column
  typedef struct packed {
    logic [2:0][2:0][PIX_W-1:0] p;
  } window_t;
endpackage

// File: rtl/sobel_window.sv
// Line memories, 3x3 window shift registers and raster counters for the Sobel stage.
module sobel_window
  import sobel_pkg::*;
#(
  parameter int ROW_SIZE   = 1280,
  parameter int ROWS       = 960,
  parameter int PIXEL_SIZE = PIX_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [PIXEL_SIZE-1:0] in_pixel,
  output window_t               win,
  output logic                  border
);
  localparam int CW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [CW-1:0] col, col_eff;
  logic [RW-1:0] row, row_eff;
  logic [PIXEL_SIZE-1:0] line1 [ROW_SIZE];
  logic [PIXEL_SIZE-1:0] line2 [ROW_SIZE];

  // sof forces the accepted pixel to position (0,0)
  always_comb begin
    col_eff = in_sof ? '0 : col;
    row_eff = in_sof ? '0 : row;
    border  = (row_eff < RW'(2)) || (col_eff < CW'(2));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      if (col_eff == CW'(ROW_SIZE-1)) begin
        col <= '0;
        row <= (row_eff == RW'(ROWS-1)) ? '0 : row_eff + 1'b1;
      end else begin
        col <= col_eff + 1'b1;
        row <= row_eff;
      end
    end
  end

  // Storage is left unreset; the border mask covers stale contents.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      line1[col_eff] <= in_pixel;
      line2[col_eff] <= line1[col_eff];
      for (int r = 0; r < 3; r++) begin
        win.p[r][0] <= win.p[r][1];
        win.p[r][1] <= win.p[r][2];
      end
      win.p[0][2] <= line2[col_eff];
      win.p[1][2] <= line1[col_eff];
      win.p[2][2] <= in_pixel;
    end
  end
endmodule

// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel edge magnitude, fixed 2-cycle latency, one output per input.
// Define SOBEL_THRESH_EN to add the threshold port and binarize the output.
module sobel_filter
  import sobel_pkg::*;
#(
  parameter int ROW_SIZE   = 1280,
  parameter int ROWS       = 960,
  parameter int PIXEL_SIZE = PIX_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [PIXEL_SIZE-1:0] in_pixel,
`ifdef SOBEL_THRESH_EN
  input  logic [PIXEL_SIZE-1:0] threshold,
`endif
  output logic                  out_valid,
  output logic                  out_sof,
  output logic [PIXEL_SIZE-1:0] out_pixel
);
  localparam int STAGES = 2;

  window_t                  win;
  logic                     border, border_q, sof_q;
  logic [STAGES:1]          vld_pipe;
  logic signed [GRAD_W-1:0] gx, gy;
  logic [GRAD_W-1:0]        ax, ay, mag;
  logic [PIXEL_SIZE-1:0]    sat, res;

  sobel_window #(
    .ROW_SIZE  (ROW_SIZE),
    .ROWS      (ROWS),
    .PIXEL_SIZE(PIXEL_SIZE)
  ) u_window (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(in_valid),
    .in_sof  (in_sof),
    .in_pixel(in_pixel),
    .win     (win),
    .border  (border)
  );

  function automatic logic signed [GRAD_W-1:0] sx(input logic [PIX_W-1:0] v);
    return $signed({{(GRAD_W-PIX_W){1'b0}}, v});
  endfunction

  always_comb begin
    gx  = (sx(win.p[0][2]) + (sx(win.p[1][2]) <<< 1) + sx(win.p[2][2]))
        - (sx(win.p[0][0]) + (sx(win.p[1][0]) <<< 1) + sx(win.p[2][0]));
    gy  = (sx(win.p[2][0]) + (sx(win.p[2][1]) <<< 1) + sx(win.p[2][2]))
        - (sx(win.p[0][0]) + (sx(win.p[0][1]) <<< 1) + sx(win.p[0][2]));
    ax  = gx[GRAD_W-1] ? $unsigned(-gx) : $unsigned(gx);
    ay  = gy[GRAD_W-1] ? $unsigned(-gy) : $unsigned(gy);
    mag = ax + ay;
    sat = (|mag[GRAD_W-1:PIX_W]) ? SAT_MAX : mag[PIX_W-1:0];
`ifdef SOBEL_THRESH_EN
    res = (sat >= threshold) ? '1 : '0;
`else
    res = sat;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      sof_q     <= 1'b0;
      border_q  <= 1'b0;
      out_sof   <= 1'b0;
      out_pixel <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], in_valid};
      sof_q     <= in_valid & in_sof;
      border_q  <= border;
      out_sof   <= vld_pipe[1] & sof_q;
      out_pixel <= (vld_pipe[1] && !border_q) ? res : '0;
    end
  end

  assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_sobel_filter.sv
// Randomized scoreboard bench for sobel_filter against an image-array reference model.
module tb_sobel_filter;
  localparam int ROW_SIZE = 8;
  localparam int ROWS     = 6;
  localparam int PS       = 12;
  localparam int PMAX     = 4095;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [PS-1:0] in_pixel = '0;
  logic          out_valid, out_sof;
  logic [PS-1:0] out_pixel;
`ifdef SOBEL_THRESH_EN
  logic [PS-1:0] threshold = 12'd300;
`endif

  sobel_filter #(.ROW_SIZE(ROW_SIZE), .ROWS(ROWS), .PIXEL_SIZE(PS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_pixel (in_pixel),
`ifdef SOBEL_THRESH_EN
    .threshold(threshold),
`endif
    .out_valid(out_valid),
    .out_sof  (out_sof),
    .out_pixel(out_pixel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int pix;
    bit sof;
    int t;
  } exp_t;

  exp_t q[$];
  int   img[ROWS][ROW_SIZE];
  int   mr = 0, mc = 0;
  int   n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Edge magnitude of the 3x3 neighbourhood ending at (r,c) of the current frame
  function automatic int ref_pix(input int r, input int c);
    int gx, gy, m;
    if (r < 2 || c < 2) return 0;
    gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
    gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
    m = iabs(gx) + iabs(gy);
    if (m > PMAX) m = PMAX;
`ifdef SOBEL_THRESH_EN
    m = (m >= int'(threshold)) ? PMAX : 0;
`endif
    return m;
  endfunction

  task automatic send(input int pix, input bit sof);
    in_valid = 1'b1;
    in_sof   = sof;
    in_pixel = PS'(pix);
    if (sof) begin mr = 0; mc = 0; end
    img[mr][mc] = pix;
    q.push_back(exp_t'{ref_pix(mr, mc), sof, cyc});
    if (mc == ROW_SIZE-1) begin
      mc = 0;
      mr = (mr == ROWS-1) ? 0 : mr + 1;
    end else mc++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic gap();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    @(posedge clk); #1;
  endtask

  // kind: 0 flat, 1 vertical step, 2 saturating step, 3 full-range random, 4 low-range random
  task automatic frame(input int kind, input bit toggle, input int len, input int sof2);
    int c, v;
    for (int i = 0; i < len; i++) begin
      c = i % ROW_SIZE;
      case (kind)
        0:       v = 500;
        1:       v = (c >= 4) ? 100 : 0;
        2:       v = (c >= 4) ? PMAX : 0;
        3:       v = $urandom_range(0, PMAX);
        default: v = $urandom_range(0, 600);
      endcase
      send(v, (i == 0) || (i == sof2));
      if (toggle) gap();
      else if (kind >= 3 && $urandom_range(0, 3) == 0) gap();
    end
  endtask

  // Monitor: every presented output must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (q.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        e = q.pop_front();
        chk("out_pixel", int'(out_pixel), e.pix);
        chk("out_sof", int'(out_sof), int'(e.sof));
        chk("latency", cyc - e.t, 2);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_sof", int'(out_sof), 0);
    chk("reset_out_pixel", int'(out_pixel), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    gap();

    frame(0, 1'b0, 48, -1);
    frame(1, 1'b0, 48, -1);
    frame(2, 1'b0, 48, -1);
    frame(1, 1'b1, 48, -1);
    frame(4, 1'b0, 20 + 48, 20);
    frame(3, 1'b0, 48, -1);

    // mid-frame reset: in-flight pixels are dropped, counters restart at (0,0)
    frame(4, 1'b0, 10, -1);
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    q.delete();
    mr = 0;
    mc = 0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_gap0", int'(out_valid), 0);
    @(negedge clk);
    chk("post_reset_gap1", int'(out_valid), 0);
    @(posedge clk); #1;
    for (int i = 0; i < 48; i++) send($urandom_range(0, 800), 1'b0);
    frame(4, 1'b0, 96, -1);
    frame(3, 1'b0, 48, -1);

    repeat (6) gap();
    chk("drain_outstanding", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
